// File: rtl/alu_chk_pkg.sv
// rtl/alu_chk_pkg.sv - shared types and constants for the ALU protocol checker
package alu_chk_pkg;

  // Violation classes; the value is both the viol_code and the viol_mask bit index
  typedef enum logic [2:0] {
    V_RESET = 3'd0,
    V_INPV  = 3'd1,
    V_CMDA  = 3'd2,
    V_CMDL  = 3'd3,
    V_ROT   = 3'd4,
    V_WAIT  = 3'd5
  } viol_e;

  localparam int NUM_VIOL = 6;

  // Rotate commands in logic mode
  localparam int CMD_ROL = 12;
  localparam int CMD_ROR = 13;

  // Commands that consume both operands, one bit per command value
  // Arith: ADD, SUB, ADD_CIN, SUB_CIN, CMP, MUL_INC, MUL_SHL
  localparam logic [15:0] TWO_OP_ARITH = 16'h070F;
  // Logic: AND, NAND, OR, NOR, XOR, XNOR, ROL, ROR
  localparam logic [15:0] TWO_OP_LOGIC = 16'h303F;

  // Operand wait-window states
  typedef logic [1:0] wait_state_e;
  localparam wait_state_e ST_IDLE   = 2'd0;
  localparam wait_state_e ST_WAIT_A = 2'd1;
  localparam wait_state_e ST_WAIT_B = 2'd2;
  localparam wait_state_e ST_CHECK  = 2'd3;

  // True when the command (zero-extended) needs both operands in the given mode
  function automatic logic is_two_op(input logic mode, input logic [31:0] cmd);
    return (cmd < 32'd16) && (mode ? TWO_OP_ARITH[cmd[3:0]] : TWO_OP_LOGIC[cmd[3:0]]);
  endfunction

endpackage

// File: rtl/alu_chk_err_window.sv
// rtl/alu_chk_err_window.sv - armed/count/expire tracker for a bounded ERR response
module alu_chk_err_window #(
  parameter int ERR_WINDOW = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  input  logic hit,
  output logic expire
);

  localparam int CW = $clog2(ERR_WINDOW + 1);

  logic          armed;
  logic [CW-1:0] count;

  // Last cycle of the window with no ERR; a reload on the same edge supersedes it
  assign expire = armed && (count == CW'(1)) && !hit && !trigger;

  // Arm or reload on trigger, disarm on ERR or when the window runs out
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
      count <= '0;
    end else if (trigger) begin
      armed <= 1'b1;
      count <= CW'(ERR_WINDOW);
    end else if (armed && (hit || count == CW'(1))) begin
      armed <= 1'b0;
      count <= '0;
    end else if (armed) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_protocol_checker.sv
// rtl/alu_protocol_checker.sv - watches ALU pins and reports protocol/response violations
module alu_protocol_checker
  import alu_chk_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CMD_WIDTH   = 4,
  parameter int ARITH_MAX   = 10,
  parameter int LOGIC_MAX   = 13,
  parameter int ERR_WINDOW  = 3,
  parameter int WAIT_CYCLES = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    clr,
  input  logic                    CE,
  input  logic                    MODE,
  input  logic                    CIN,
  input  logic [1:0]              INP_VALID,
  input  logic [CMD_WIDTH-1:0]    CMD,
  input  logic [WIDTH-1:0]        OPA,
  input  logic [WIDTH-1:0]        OPB,
  input  logic [WIDTH:0]          RES,
  input  logic                    ERR,
  input  logic                    OFLOW,
  input  logic                    COUT,
  input  logic                    G,
  input  logic                    L,
  input  logic                    E,
  output logic                    viol_valid,
  output logic [2:0]              viol_code,
  output logic [5:0]              viol_mask,
  output logic [6*CNT_WIDTH-1:0]  viol_cnt
);

  localparam int SHW = $clog2(WIDTH);
  localparam int WCW = $clog2(WAIT_CYCLES + 1);

  logic [31:0] cmd_ext;
  logic        rst_q;
  logic        inpv_pend;
  logic        cmda_pend;
  logic        cmdl_pend;
  logic        rot_trig;
  logic        rot_expire;
  logic        two_op;
  logic        missing;

  wait_state_e          wstate;
  wait_state_e          idle_next;
  logic [WCW-1:0]       wcnt;
  logic [WCW-1:0]       wcnt_inc;
  logic [CMD_WIDTH-1:0] wcmd;
  logic                 wmode;

  logic [NUM_VIOL-1:0]                fail;
  logic [2:0]                         code_next;
  logic [NUM_VIOL-1:0][CNT_WIDTH-1:0] cnt;

  // CIN, OPA and the low shift-amount bits of OPB carry no protocol obligation
  logic unused;
  assign unused = ^{CIN, OPA, OPB[SHW-1:0]};

  assign cmd_ext  = 32'(CMD);
  assign two_op   = is_two_op(MODE, cmd_ext);
  assign wcnt_inc = wcnt + 1'b1;
  assign missing  = (wstate == ST_WAIT_B) ? INP_VALID[1] : INP_VALID[0];
  assign viol_cnt = cnt;

  // A rotate by WIDTH or more positions must be answered with ERR
  assign rot_trig = !RST && CE && !MODE &&
                    (cmd_ext == CMD_ROL || cmd_ext == CMD_ROR) &&
                    (OPB[WIDTH-1:SHW] != '0);

  alu_chk_err_window #(
    .ERR_WINDOW(ERR_WINDOW)
  ) u_rot_window (
    .clk    (CLK),
    .rst    (RST),
    .trigger(rot_trig),
    .hit    (ERR),
    .expire (rot_expire)
  );

  // Remember reset release and the single-cycle ERR obligations for the next edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      rst_q     <= 1'b1;
      inpv_pend <= 1'b0;
      cmda_pend <= 1'b0;
      cmdl_pend <= 1'b0;
    end else begin
      rst_q     <= 1'b0;
      inpv_pend <= CE && (INP_VALID == 2'b00);
      cmda_pend <= CE && MODE && (cmd_ext > ARITH_MAX);
      cmdl_pend <= CE && !MODE && (cmd_ext > LOGIC_MAX);
    end
  end

  // Where a fresh operation would send the wait FSM
  always_comb begin
    idle_next = ST_IDLE;
    if (two_op && INP_VALID == 2'b01) idle_next = ST_WAIT_B;
    else if (two_op && INP_VALID == 2'b10) idle_next = ST_WAIT_A;
  end

  // Two-operand wait window: count CE cycles until the partner operand shows up
  always_ff @(posedge CLK) begin
    if (RST) begin
      wstate <= ST_IDLE;
      wcnt   <= '0;
      wcmd   <= '0;
      wmode  <= 1'b0;
    end else begin
      case (wstate)
        ST_IDLE: begin
          if (CE) begin
            wstate <= idle_next;
            wcnt   <= '0;
            wcmd   <= CMD;
            wmode  <= MODE;
          end
        end
        ST_WAIT_A, ST_WAIT_B: begin
          if (CE) begin
            if (CMD != wcmd || MODE != wmode) begin
              // A different operation abandons the old window and starts afresh
              wstate <= idle_next;
              wcnt   <= '0;
              wcmd   <= CMD;
              wmode  <= MODE;
            end else if (missing) begin
              wstate <= ST_IDLE;
              wcnt   <= '0;
            end else begin
              wcnt <= wcnt_inc;
              if (wcnt_inc == WCW'(WAIT_CYCLES)) wstate <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          wstate <= ST_IDLE;
          wcnt   <= '0;
        end
        default: wstate <= ST_IDLE;
      endcase
    end
  end

  // Evaluate every violation class at this edge; only the reset check survives RST
  always_comb begin
    fail = '0;
    if (!RST) begin
      fail[V_RESET] = rst_q && ((RES != '0) || COUT || OFLOW || G || L || E);
      fail[V_INPV]  = inpv_pend && !ERR;
      fail[V_CMDA]  = cmda_pend && !ERR;
      fail[V_CMDL]  = cmdl_pend && !ERR;
      fail[V_ROT]   = rot_expire;
      fail[V_WAIT]  = (wstate == ST_CHECK) && !ERR;
    end
  end

  // Lowest failing class index wins the code
  always_comb begin
    code_next = 3'd0;
    for (int k = NUM_VIOL - 1; k >= 0; k--) begin
      if (fail[k]) code_next = 3'(k);
    end
  end

  // Register the pulse, sticky mask and saturating counters; clr first, then new failures
  always_ff @(posedge CLK) begin
    if (RST) begin
      viol_valid <= 1'b0;
      viol_code  <= 3'd0;
      viol_mask  <= '0;
      cnt        <= '0;
    end else begin
      viol_valid <= |fail;
      viol_code  <= code_next;
      viol_mask  <= clr ? fail : (viol_mask | fail);
      for (int k = 0; k < NUM_VIOL; k++) begin
        if (clr) begin
          cnt[k] <= fail[k] ? CNT_WIDTH'(1) : '0;
        end else if (fail[k] && (cnt[k] != '1)) begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_protocol_checker.sv
// tb/tb_alu_protocol_checker.sv - scoreboard bench for the ALU protocol checker
module tb_alu_protocol_checker;

  localparam int WIDTH = 8;
  localparam int CMD_WIDTH = 4;
  localparam int CNT_WIDTH = 4;

  logic                   CLK;
  logic                   RST;
  logic                   clr;
  logic                   CE;
  logic                   MODE;
  logic                   CIN;
  logic [1:0]             INP_VALID;
  logic [CMD_WIDTH-1:0]   CMD;
  logic [WIDTH-1:0]       OPA;
  logic [WIDTH-1:0]       OPB;
  logic [WIDTH:0]         RES;
  logic                   ERR;
  logic                   OFLOW;
  logic                   COUT;
  logic                   G;
  logic                   L;
  logic                   E;
  logic                   viol_valid;
  logic [2:0]             viol_code;
  logic [5:0]             viol_mask;
  logic [6*CNT_WIDTH-1:0] viol_cnt;

  typedef struct {
    logic [2:0]  code;
    logic [5:0]  mask;
    logic [23:0] cnt;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;

  alu_protocol_checker #(
    .WIDTH      (WIDTH),
    .CMD_WIDTH  (CMD_WIDTH),
    .ARITH_MAX  (10),
    .LOGIC_MAX  (13),
    .ERR_WINDOW (3),
    .WAIT_CYCLES(16),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (clr),
    .CE        (CE),
    .MODE      (MODE),
    .CIN       (CIN),
    .INP_VALID (INP_VALID),
    .CMD       (CMD),
    .OPA       (OPA),
    .OPB       (OPB),
    .RES       (RES),
    .ERR       (ERR),
    .OFLOW     (OFLOW),
    .COUT      (COUT),
    .G         (G),
    .L         (L),
    .E         (E),
    .viol_valid(viol_valid),
    .viol_code (viol_code),
    .viol_mask (viol_mask),
    .viol_cnt  (viol_cnt)
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Edge index so pulses can be tied to the edge that should produce them
  always @(posedge CLK) edge_n <= edge_n + 1;

  // Hard time limit
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: every pulse pops one expectation; an overdue expectation is a missed pulse
  always @(negedge CLK) begin
    if (viol_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: code %0d mask %b at edge %0d, expected no pulse",
                 viol_code, viol_mask, edge_n);
      end else begin
        e = sb.pop_front();
        chk("pulse_edge", 32'(edge_n), 32'(e.at));
        chk("viol_code", 32'(viol_code), 32'(e.code));
        chk("viol_mask", 32'(viol_mask), 32'(e.mask));
        chk("viol_cnt", 32'(viol_cnt), 32'(e.cnt));
      end
    end else if (sb.size() != 0 && sb[0].at <= edge_n) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_pulse: no pulse at edge %0d, expected code %0d", edge_n, e.code);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_pulse(input logic [2:0] code, input logic [5:0] mask, input logic [23:0] c);
    exp_t x;
    x.code = code;
    x.mask = mask;
    x.cnt  = c;
    x.at   = edge_n + 1;
    sb.push_back(x);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  initial begin
    logic [23:0] c;
    int k1;
    RST = 1'b1; clr = 1'b0; CE = 1'b0; MODE = 1'b0; CIN = 1'b0;
    INP_VALID = 2'b00; CMD = '0; OPA = '0; OPB = '0;
    RES = 9'h001; ERR = 1'b0; OFLOW = 1'b0; COUT = 1'b0; G = 1'b0; L = 1'b0; E = 1'b0;
    repeat (3) cyc();
    chk("reset_valid", 32'(viol_valid), 32'd0);
    chk("reset_code", 32'(viol_code), 32'd0);
    chk("reset_mask", 32'(viol_mask), 32'd0);
    chk("reset_cnt", 32'(viol_cnt), 32'd0);

    // Nonzero RES at the first edge after release
    RST = 1'b0;
    expect_pulse(3'd0, 6'b000001, 24'h000001);
    cyc();
    RES = '0;
    repeat (2) cyc();
    do_clr();

    // CE with no operand valid: ERR missing, then ERR present
    CE = 1'b1; INP_VALID = 2'b00;
    cyc();
    CE = 1'b0;
    expect_pulse(3'd1, 6'b000010, 24'h000010);
    cyc();
    cyc();
    CE = 1'b1;
    cyc();
    CE = 1'b0; ERR = 1'b1;
    cyc();
    ERR = 1'b0;
    cyc();

    // Oversized rotate: ERR on the last allowed edge passes
    MODE = 1'b0; CMD = 4'd13; OPB = 8'h10; INP_VALID = 2'b11; CE = 1'b1;
    cyc();
    CE = 1'b0;
    cyc();
    cyc();
    ERR = 1'b1;
    cyc();
    ERR = 1'b0;
    repeat (4) cyc();

    // Oversized rotate with ERR never arriving
    CE = 1'b1;
    cyc();
    CE = 1'b0;
    cyc();
    cyc();
    expect_pulse(3'd4, 6'b010010, 24'h010010);
    cyc();
    OPB = '0; CMD = '0; INP_VALID = 2'b00;
    repeat (4) cyc();
    do_clr();

    // ADD with only A valid for the whole window
    MODE = 1'b1; CMD = 4'd0; INP_VALID = 2'b01; CE = 1'b1;
    cyc();
    repeat (16) cyc();
    CE = 1'b0; INP_VALID = 2'b00;
    expect_pulse(3'd5, 6'b100000, 24'h100000);
    cyc();
    repeat (3) cyc();

    // ADD whose partner operand arrives on cycle 10
    CE = 1'b1; INP_VALID = 2'b01;
    cyc();
    repeat (9) cyc();
    INP_VALID = 2'b11;
    cyc();
    CE = 1'b0; INP_VALID = 2'b00;
    repeat (20) cyc();
    MODE = 1'b0;
    do_clr();

    // Illegal arith command with no operands: two classes at once
    MODE = 1'b1; CMD = 4'd15; INP_VALID = 2'b00; CE = 1'b1;
    cyc();
    CE = 1'b0; MODE = 1'b0; CMD = '0;
    expect_pulse(3'd1, 6'b000110, 24'h000110);
    cyc();
    cyc();

    // Drive the INPV counter into saturation and one past it
    for (int i = 1; i <= 15; i++) begin
      CE = 1'b1; INP_VALID = 2'b00;
      cyc();
      CE = 1'b0;
      k1 = (i + 1 > 15) ? 15 : i + 1;
      c = 24'h000100;
      c[7:4] = 4'(k1);
      expect_pulse(3'd1, 6'b000110, c);
      cyc();
    end

    // clr on the same edge as a failure
    CE = 1'b1; INP_VALID = 2'b00;
    cyc();
    CE = 1'b0; clr = 1'b1;
    expect_pulse(3'd1, 6'b000010, 24'h000010);
    cyc();
    clr = 1'b0;
    cyc();

    // Logic command just past the legal range
    CE = 1'b1; MODE = 1'b0; CMD = 4'd14; INP_VALID = 2'b11;
    cyc();
    CE = 1'b0; CMD = '0;
    expect_pulse(3'd3, 6'b001010, 24'h001010);
    cyc();
    cyc();

    // Highest legal arith command stays quiet
    CE = 1'b1; MODE = 1'b1; CMD = 4'd10; INP_VALID = 2'b11;
    cyc();
    CE = 1'b0; MODE = 1'b0; CMD = '0; INP_VALID = 2'b00;
    repeat (3) cyc();

    for (int t = 0; t < 20 && sb.size() != 0; t++) cyc();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
